// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter block and its downstream decimation buffer.
// Contents: sample width and type, input-side FSM state encoding, default tap count
// from which the warm-up length is derived.
package fir_pkg;

    localparam int unsigned SAMPLE_W       = 16;
    localparam int unsigned NUM_TAPS       = 63;
    // The filter pipeline needs one sample per tap before its output is meaningful.
    localparam int unsigned DEFAULT_WARMUP = NUM_TAPS;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWarmup = 2'd1,
        StRun    = 2'd2
    } state_e;

endpackage

// File: rtl/fir_decim_buffer_if.sv
// Sample stream bundle between the FIR output, the decimation buffer and its consumer.
//   y_in, in_valid      : filtered sample arriving from the FIR
//   out_data, out_valid : head-of-FIFO sample offered to the consumer
//   out_ready           : consumer accepts out_data this cycle
// slave  : the buffer side (consumes y_in, produces out_data)
// master : the environment side (filter + consumer)
interface fir_decim_buffer_if;
    import fir_pkg::*;

    sample_t y_in;
    logic    in_valid;
    sample_t out_data;
    logic    out_valid;
    logic    out_ready;

    modport slave (
        input  y_in,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output y_in,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO for filtered samples.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (pointers and level only)
//   wr_en, wr_data  : write request; caller guarantees no write when full unless reading
//   rd_en           : pop the head word
//   rd_data         : head word, 0 when empty
//   level           : occupancy 0..DEPTH
//   full, empty     : occupancy flags
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  sample_t       wr_data,
    input  logic          rd_en,
    output sample_t       rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_q;
    logic [AW:0]     level_d;

    always_comb begin
        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Storage is not reset; stale words are hidden because level is 0.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = empty ? sample_t'(0) : mem[rd_ptr_q];

endmodule

// File: rtl/fir_decim_buffer.sv
// Downstream stage of the FIR block: drops the warm-up transient after each enable,
// keeps every DECIM-th sample and buffers it in a FWFT FIFO toward a valid/ready consumer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stream enable; low returns the input side to idle (FIFO keeps draining)
//   bus        : sample stream (y_in/in_valid in, out_data/out_valid/out_ready out)
//   level      : FIFO occupancy
//   ovf        : sticky, a kept sample was lost to a full FIFO; ovf_clr clears it
//   drop_cnt   : saturating count of lost samples (only with DROP_CNT_EN defined)
// Optional feature macro: DROP_CNT_EN.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int unsigned DECIM  = 4,
    parameter int unsigned WARMUP = DEFAULT_WARMUP,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    fir_decim_buffer_if.slave  bus,
    output logic [AW:0]        level,
    output logic               ovf,
    input  logic               ovf_clr
`ifdef DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int unsigned CW    = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int unsigned PW    = (DECIM < 2) ? 1 : $clog2(DECIM);
    localparam int unsigned WLAST = (WARMUP == 0) ? 0 : WARMUP - 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            keep;
    logic            wr, rd, drop;
    logic            full, empty;
    logic            ovf_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        phase_d = phase_q;
        keep    = 1'b0;
        if (!en) begin
            state_d = StIdle;
            wcnt_d  = '0;
            phase_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wcnt_d  = '0;
                    phase_d = '0;
                    state_d = (WARMUP == 0) ? StRun : StWarmup;
                end
                StWarmup: begin
                    if (bus.in_valid) begin
                        wcnt_d = wcnt_q + CW'(1);
                        // The sample that completes the warm-up is itself discarded.
                        if (wcnt_q == CW'(WLAST)) state_d = StRun;
                    end
                end
                StRun: begin
                    if (bus.in_valid) begin
                        keep    = (phase_q == '0);
                        phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            phase_q <= phase_d;
        end
    end

    assign rd   = bus.out_valid && bus.out_ready;
    // A simultaneous read frees the slot, so a full FIFO can still accept.
    assign wr   = keep && (!full || rd);
    assign drop = keep && full && !rd;

    fir_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr),
        .wr_data (bus.y_in),
        .rd_en   (rd),
        .rd_data (bus.out_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign bus.out_valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;

`ifdef DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (ovf_clr) begin
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Scoreboard bench for fir_decim_buffer (DECIM=4, WARMUP=63, DEPTH=8).
module tb_fir_decim_buffer;
    import fir_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] level;
    logic       ovf;
    logic       ovf_clr;
`ifdef DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    fir_decim_buffer_if bus ();

    fir_decim_buffer #(
        .DECIM  (4),
        .WARMUP (63),
        .DEPTH  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bus      (bus),
        .level    (level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`ifdef DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every accepted output word is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got %h, required no output", bus.out_data);
            end else begin
                logic [15:0] e;
                logic [15:0] g;
                e = exp_q.pop_front();
                g = bus.out_data;
                if (g !== e) begin
                    bad++;
                    $display("FAIL out_data: got %h, required %h", g, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input bit push_it);
        bus.y_in     = 16'(v);
        bus.in_valid = 1'b1;
        if (push_it) exp_q.push_back(16'(v));
        tick();
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        for (int c = 0; c < 40 && bus.out_valid; c++) tick();
        chk("drain_valid", int'(bus.out_valid), 0);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_level", int'(level), 0);
    endtask

    // Enable from idle, feed 63 warm-up samples, then one kept sample base+63.
    task automatic warmup(input int base);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        en            = 1'b1;
        tick();
        for (int j = 0; j < 63; j++) send(base + j, 1'b0);
        chk("warm_quiet_valid", int'(bus.out_valid), 0);
        chk("warm_quiet_level", int'(level), 0);
        send(base + 63, 1'b1);
        chk("first_valid", int'(bus.out_valid), 1);
        chk("first_data", int'(bus.out_data), base + 63);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        ovf_clr       = 1'b0;
        bus.y_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ramp: 0..62 discarded, then 63, 67, 71, ...
        warmup(0);
        for (int i = 64; i <= 82; i++) send(i, ((i - 63) % 4) == 0);
        drain();

        // Overflow with consumer stalled: first 8 kept samples retained.
        bus.out_ready = 1'b0;
        for (int j = 0; j < 160; j++) begin
            send(1000 + j, (j % 4 == 0) && (j < 32));
            if (j == 28) begin
                chk("fill8_level", int'(level), 8);
                chk("fill8_ovf", int'(ovf), 0);
            end
            if (j == 32) chk("ovf_on_9th", int'(ovf), 1);
        end
        bus.in_valid = 1'b0;
        chk("ovf_level", int'(level), 8);
        chk("ovf_sticky", int'(ovf), 1);
`ifdef DROP_CNT_EN
        chk("drop_cnt_32", int'(drop_cnt), 32);
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_plain", int'(ovf), 0);
`ifdef DROP_CNT_EN
        chk("drop_cnt_clr", int'(drop_cnt), 0);
`endif

        // Full FIFO, read and kept write on the same cycle.
        bus.out_ready = 1'b1;
        send(2000, 1'b1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("full_rw_level", int'(level), 8);
        chk("full_rw_ovf", int'(ovf), 0);
        drain();

        // en dropped mid-run with 3 samples buffered (phase starts at 1 here).
        bus.out_ready = 1'b0;
        for (int j = 0; j < 12; j++) send(3000 + j, (j == 3) || (j == 7) || (j == 11));
        chk("three_level", int'(level), 3);
        en = 1'b0;
        for (int j = 0; j < 3; j++) send(9999, 1'b0);
        chk("disabled_level", int'(level), 3);
        drain();
        warmup(4000);
        drain();

        // Negative bit patterns (phase 1 after warm-up sample).
        for (int j = 0; j < 3; j++) send(5000 + j, 1'b0);
        send(32'h8000, 1'b1);
        for (int j = 0; j < 3; j++) send(5100 + j, 1'b0);
        send(32'hFFFF, 1'b1);
        drain();

        // Fill again, then ovf_clr coinciding with a drop.
        bus.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) send(5200 + j, 1'b0);
        for (int j = 0; j < 36; j++) send(6000 + j, (j % 4 == 0) && (j < 32));
        chk("refill_level", int'(level), 8);
        chk("refill_ovf", int'(ovf), 1);
        ovf_clr = 1'b1;
        send(7777, 1'b0);
        ovf_clr      = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_vs_drop_ovf", int'(ovf), 1);
`ifdef DROP_CNT_EN
        chk("clr_vs_drop_cnt", int'(drop_cnt), 1);
`endif

        // Drain 3 to level 5, then asynchronous reset between edges.
        bus.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        bus.out_ready = 1'b0;
        chk("pre_rst_level", int'(level), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(bus.out_valid), 0);
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_ovf", int'(ovf), 0);
`ifdef DROP_CNT_EN
        chk("async_rst_cnt", int'(drop_cnt), 0);
`endif
        exp_q.delete();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Back in idle: a full warm-up must precede the next write.
        warmup(8000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
